// File: rtl/rs232_rx_stream.sv
// rs232_rx_stream: oversampling 8N1 UART receiver feeding a 32-bit stb/ack stream.
// Each received byte is delivered zero-extended in output_rx[7:0].
// Optional build macro RS232_RX_FIFO_EN: replaces the single holding register
// with a 4-entry FIFO. Default build (macro undefined) uses the holding register.
module rs232_rx_stream #(
    parameter int CLOCK_FREQUENCY = 100000000,
    parameter int BAUD_RATE       = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [31:0] output_rx,
    output logic        output_rx_stb,
    input  logic        output_rx_ack,
    output logic        framing_error,
    output logic        overrun
);

    localparam int N  = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] HALF_LOAD = CW'(N / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            rx_p0;
    logic            rx_p1;
    logic            rxs;
    logic            vld_p0;
    logic            vld_p1;
    logic            armed;
    logic [CW-1:0]   cnt;
    logic            cnt_zero;
    logic [2:0]      bit_idx;
    logic [7:0]      shift_p;
    logic            load_half;
    logic            load_full;
    logic            shift_en;
    logic            byte_done;
    logic            frame_bad;
    logic            pop;

    assign rxs      = rx_p1;
    assign cnt_zero = (cnt == '0);
    assign pop      = output_rx_stb & output_rx_ack;

    // Two-flop synchronizer for the pin; vld_pN marks when rxs reflects the real line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_p0  <= 1'b1;
            rx_p1  <= 1'b1;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            rx_p0  <= rx;
            rx_p1  <= rx_p0;
            vld_p0 <= 1'b1;
            vld_p1 <= vld_p0;
        end
    end

    // Start detection is armed only after the real line has been seen high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed <= 1'b0;
        end else if (vld_p1 && rxs) begin
            armed <= 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (armed && !rxs) state_nxt = S_START;
            S_START: if (cnt_zero) state_nxt = rxs ? S_IDLE : S_DATA;
            S_DATA:  if (cnt_zero && (bit_idx == 3'd7)) state_nxt = S_STOP;
            S_STOP:  if (cnt_zero) state_nxt = rxs ? S_IDLE : S_BREAK;
            S_BREAK: if (rxs) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: counter reloads, data shift strobe and end-of-frame events
    always_comb begin
        load_half = 1'b0;
        load_full = 1'b0;
        shift_en  = 1'b0;
        byte_done = 1'b0;
        frame_bad = 1'b0;
        case (state)
            S_IDLE:  load_half = armed & ~rxs;
            S_START: load_full = cnt_zero & ~rxs;
            S_DATA: begin
                load_full = cnt_zero;
                shift_en  = cnt_zero;
            end
            S_STOP: begin
                byte_done = cnt_zero & rxs;
                frame_bad = cnt_zero & ~rxs;
            end
            default: ;
        endcase
    end

    // Sample-point down-counter and data bit index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
        end else begin
            if (load_half) begin
                cnt <= HALF_LOAD;
            end else if (load_full) begin
                cnt <= FULL_LOAD;
            end else if (!cnt_zero) begin
                cnt <= cnt - CW'(1);
            end
            if (state == S_START) begin
                bit_idx <= 3'd0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    // Data bits land LSB first at their sample points
    always_ff @(posedge clk) begin
        if (shift_en) begin
            shift_p[bit_idx] <= rxs;
        end
    end

    // Framing error pulse, aligned with the cycle a good byte would appear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            framing_error <= 1'b0;
        end else begin
            framing_error <= frame_bad;
        end
    end

`ifdef RS232_RX_FIFO_EN
    logic [7:0] fifo_mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;
    logic       push;

    assign push          = byte_done & ((count != 3'd4) | pop);
    assign output_rx_stb = (count != 3'd0);
    assign output_rx     = {24'd0, fifo_mem[rd_ptr]};

    // FIFO storage, pointers and occupancy; a full FIFO drops the new byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                fifo_mem[i] <= 8'd0;
            end
            wr_ptr  <= 2'd0;
            rd_ptr  <= 2'd0;
            count   <= 3'd0;
            overrun <= 1'b0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= shift_p;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            count   <= count + 3'(push) - 3'(pop);
            overrun <= byte_done & (count == 3'd4) & ~pop;
        end
    end
`else
    logic [7:0] hold_byte;

    assign output_rx = {24'd0, hold_byte};

    // Single holding register; a byte may load in the same cycle the old word is acked
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_byte     <= 8'd0;
            output_rx_stb <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            overrun <= byte_done & output_rx_stb & ~output_rx_ack;
            if (byte_done && (!output_rx_stb || output_rx_ack)) begin
                hold_byte     <= shift_p;
                output_rx_stb <= 1'b1;
            end else if (pop) begin
                output_rx_stb <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rs232_rx_stream.sv
// tb_rs232_rx_stream: directed bench for rs232_rx_stream with N = 16 clocks per bit.
// Inputs change 1 ns after the rising edge; outputs are observed on the falling edge.
module tb_rs232_rx_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic        output_rx_ack;
    logic [31:0] output_rx;
    logic        output_rx_stb;
    logic        framing_error;
    logic        overrun;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          frame_start_cyc = 0;
    int          rise_cyc = 0;
    int          ferr_cnt = 0;
    int          ovr_cnt = 0;
    int          stb_hi_cnt = 0;
    logic        stb_q = 1'b0;
    logic [31:0] got [$];

    rs232_rx_stream #(
        .CLOCK_FREQUENCY(1600),
        .BAUD_RATE      (100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .output_rx    (output_rx),
        .output_rx_stb(output_rx_stb),
        .output_rx_ack(output_rx_ack),
        .framing_error(framing_error),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Observe the stream and the event pulses
    always @(negedge clk) begin
        if (output_rx_stb && output_rx_ack) got.push_back(output_rx);
        if (framing_error) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (output_rx_stb) stb_hi_cnt++;
        if (output_rx_stb && !stb_q) rise_cyc = cyc;
        stb_q = output_rx_stb;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] q_at(input int i);
        return (i < got.size()) ? got[i] : 32'hxxxxxxxx;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives ncyc cycles of a frame: start, 8 data bits LSB first, then stopv held
    task automatic drive_frame(input logic [7:0] b, input logic stopv, input int ncyc);
        frame_start_cyc = cyc;
        for (int i = 0; i < ncyc; i++) begin
            if (i < 16) rx = 1'b0;
            else if (i < 144) rx = b[(i - 16) / 16];
            else rx = stopv;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        drive_frame(b, 1'b1, 160);
    endtask

    int stb0;
    int ovr0;
    int ferr0;

    initial begin
        rst = 1'b0;
        rx = 1'b1;
        output_rx_ack = 1'b0;
        idle(3);
        check("reset_output_rx", output_rx, 32'h0);
        check("reset_stb", {31'd0, output_rx_stb}, 32'd0);
        check("reset_framing_error", {31'd0, framing_error}, 32'd0);
        check("reset_overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b1;
        idle(20);

        // Single byte with ack held high
        output_rx_ack = 1'b1;
        got.delete();
        stb0 = stb_hi_cnt;
        send(8'h55);
        idle(10);
        check("single_count", got.size(), 32'd1);
        check("single_data", q_at(0), 32'h00000055);
        check("single_latency", rise_cyc - frame_start_cyc, 32'd155);
        check("single_stb_width", stb_hi_cnt - stb0, 32'd1);

        // Back-to-back frames
        got.delete();
        ferr0 = ferr_cnt;
        ovr0 = ovr_cnt;
        send(8'h00);
        send(8'hFF);
        send(8'hA5);
        idle(10);
        check("b2b_count", got.size(), 32'd3);
        check("b2b_word0", q_at(0), 32'h00000000);
        check("b2b_word1", q_at(1), 32'h000000FF);
        check("b2b_word2", q_at(2), 32'h000000A5);
        check("b2b_framing", ferr_cnt - ferr0, 32'd0);
        check("b2b_overrun", ovr_cnt - ovr0, 32'd0);

        // Short glitch is rejected at the start sample
        got.delete();
        stb0 = stb_hi_cnt;
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(40);
        check("glitch_no_stb", stb_hi_cnt - stb0, 32'd0);
        check("glitch_no_word", got.size(), 32'd0);

        // Framing error followed by a good frame
        ferr0 = ferr_cnt;
        stb0 = stb_hi_cnt;
        drive_frame(8'h3C, 1'b0, 144 + 320);
        rx = 1'b1;
        idle(40);
        check("ferr_pulse_count", ferr_cnt - ferr0, 32'd1);
        check("ferr_no_stb", stb_hi_cnt - stb0, 32'd0);
        send(8'h12);
        idle(10);
        check("after_ferr_count", got.size(), 32'd1);
        check("after_ferr_data", q_at(0), 32'h00000012);

        // Overrun with the consumer stalled
        output_rx_ack = 1'b0;
        got.delete();
        ovr0 = ovr_cnt;
`ifdef RS232_RX_FIFO_EN
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        send(8'h55);
        idle(10);
        check("ovr_pulse_count", ovr_cnt - ovr0, 32'd1);
        check("ovr_head", output_rx, 32'h00000011);
        check("ovr_stb", {31'd0, output_rx_stb}, 32'd1);
        output_rx_ack = 1'b1;
        idle(4);
        output_rx_ack = 1'b0;
        check("fifo_drain_count", got.size(), 32'd4);
        check("fifo_drain0", q_at(0), 32'h00000011);
        check("fifo_drain1", q_at(1), 32'h00000022);
        check("fifo_drain2", q_at(2), 32'h00000033);
        check("fifo_drain3", q_at(3), 32'h00000044);
        check("fifo_drain_stb", {31'd0, output_rx_stb}, 32'd0);
`else
        send(8'h11);
        send(8'h22);
        idle(10);
        check("ovr_pulse_count", ovr_cnt - ovr0, 32'd1);
        check("ovr_held", output_rx, 32'h00000011);
        check("ovr_stb", {31'd0, output_rx_stb}, 32'd1);
        check("ovr_no_word", got.size(), 32'd0);

        // Ack lands in the same cycle the next byte completes
        fork
            send(8'h33);
            begin
                repeat (154) @(posedge clk);
                #1 output_rx_ack = 1'b1;
                @(posedge clk);
                #1 output_rx_ack = 1'b0;
            end
        join
        idle(10);
        check("simul_acked", q_at(0), 32'h00000011);
        check("simul_new_data", output_rx, 32'h00000033);
        check("simul_stb", {31'd0, output_rx_stb}, 32'd1);
        check("simul_no_overrun", ovr_cnt - ovr0, 32'd1);
        output_rx_ack = 1'b1;
        idle(1);
        output_rx_ack = 1'b0;
        idle(2);
        check("simul_drain", q_at(1), 32'h00000033);
        check("simul_drain_stb", {31'd0, output_rx_stb}, 32'd0);
`endif

        // Reset in the middle of data bit 3 with a word held; line stays low past release
        output_rx_ack = 1'b0;
        idle(20);
        send(8'h99);
        idle(10);
        got.delete();
        ferr0 = ferr_cnt;
        drive_frame(8'hC3, 1'b1, 72);
        rst = 1'b0;
        idle(3);
        check("midrst_output_rx", output_rx, 32'h0);
        check("midrst_stb", {31'd0, output_rx_stb}, 32'd0);
        rst = 1'b1;
        idle(20);
        rx = 1'b1;
        idle(200);
        check("midrst_no_false_start", {31'd0, output_rx_stb}, 32'd0);
        check("midrst_no_ferr", ferr_cnt - ferr0, 32'd0);
        output_rx_ack = 1'b1;
        send(8'h7E);
        idle(10);
        check("midrst_count", got.size(), 32'd1);
        check("midrst_data", q_at(0), 32'h0000007E);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rs232_rx_stream.md
# rs232_rx_stream

Serial UART receiver that turns the asynchronous RS-232 RX pin into the 32-bit `stb`/`ack` stream consumed by the `input_rs232_rx` port of the user design. It is the receive-side counterpart of the stream-fed RS-232 transmitter: it oversamples 8N1 frames and delivers each received byte zero-extended to 32 bits. It sits between the board RX pin and `user_design`.

## Interface

- `CLOCK_FREQUENCY`, default 100000000: `clk` frequency in Hz.
- `BAUD_RATE`, default 115200: line rate in bit/s. `N = CLOCK_FREQUENCY / BAUD_RATE` uses integer division and must be ≥ 8.

Ports:

- `clk`  input  1  system clock; all logic is on the rising edge.
- `rst`  input  1  asynchronous, active-low reset (asserts when 0, independent of `clk`).
- `rx`  input  1  serial line; idles high; asynchronous to `clk`.
- `output_rx`  output  32  received byte in [7:0]; [31:8] always 0.
- `output_rx_stb`  output  1  `output_rx` is valid.
- `output_rx_ack`  input  1  consumer accepts the word.
- `framing_error`  output  1  one-cycle pulse when a stop bit samples 0.
- `overrun`  output  1  one-cycle pulse when a completed byte is dropped.

## Operation

- **Synchronizer:** `rx` passes through 2 flops, both reset to 1. All logic below uses the synchronized value `rxs`.
- **Bit counter:** a down-counter, width `clog2(N)`, is reloaded at each sample point.
- **States:**
  - IDLE: on `rxs` = 0, load `N/2 - 1` (integer division) and go to START.
  - START: when the counter reaches 0, sample `rxs`. If 1 (glitch), go to IDLE. If 0, load `N - 1` and go to DATA with bit index 0.
  - DATA: at each counter expiry, shift `rxs` into bit [index], LSB first. After bit 7, load `N - 1` and go to STOP.
  - STOP: at counter expiry, sample `rxs`.
    - If 1: the byte is complete; go to IDLE.
    - If 0: pulse `framing_error`, discard the byte, go to BREAK.
  - BREAK: wait for `rxs` = 1, then go to IDLE. No new start bit is detected while in BREAK.
- **Output buffer:** one holding register. A byte completing while the register is empty loads it, and `output_rx_stb` rises. `output_rx_stb` stays high, with data stable, until a cycle in which `output_rx_stb` and `output_rx_ack` are both 1. `output_rx_ack` while `output_rx_stb` is 0 is ignored.
- **Simultaneous complete and ack:** if a byte completes in the same cycle the held word is acked, the new byte is loaded, `output_rx_stb` stays 1, and there is no overrun.
- **Full buffer:** if a byte completes while the register is full and not being acked, the new byte is dropped and `overrun` pulses. The held word is unaffected.

## Timing

- **Reset values:** `output_rx` = 0, `output_rx_stb` = 0, `framing_error` = 0, `overrun` = 0, state = IDLE, synchronizer flops = 1.
- **Reset mid-frame:** the partial byte is discarded and any held word is lost. After release, the receiver needs `rxs` to be high before it detects a new falling edge, so a line held low through reset release is never taken as a start bit.
- **Sample points:** let t0 be the first cycle with `rxs` = 0. Samples are taken at t0 + N/2 (start), t0 + N/2 + k·N for data bit k−1 (k = 1..8), and t0 + N/2 + 9N (stop).
- **Latency:** `output_rx_stb` is high in the cycle after the stop sample. The `framing_error` and `overrun` pulses occur in that same cycle.
- **Pin to IDLE:** a falling edge at the `rx` pin reaches `rxs` 2 cycles later. The next frame can be detected starting the cycle after the stop sample.

## Configuration

- `RS232_RX_FIFO_EN` defined: the holding register is replaced by a 4-entry FIFO with 2-bit read/write pointers that wrap and a 3-bit count.
  - `output_rx` is the head entry.
  - `output_rx_stb` = (count ≠ 0).
  - `overrun` pulses only when count = 4 and there is no simultaneous pop.
  - A push and a pop in the same cycle leave count unchanged.
- Undefined: single holding register, exactly as described in Operation.

## Test plan

Bench parameters: `CLOCK_FREQUENCY` = 1600, `BAUD_RATE` = 100, so N = 16.

- **Single byte:** send 8N1 frame 0x55 with `output_rx_ack` held 1 → `output_rx` = 0x00000055 with `output_rx_stb` high for exactly 1 cycle, at t0 + 8 + 144 + 1.
- **Back-to-back:** frames 0x00, 0xFF, 0xA5 back-to-back with `output_rx_ack` = 1 → three words in order, `framing_error` and `overrun` never pulse.
- **Glitch:** a 4-cycle low pulse on `rx` → no `output_rx_stb`, state returns to IDLE.
- **Framing error:** frame 0x3C with the stop bit driven 0 for 20 bit times → one `framing_error` pulse, no `output_rx_stb`. A following valid 0x12 is received correctly.
- **Overrun:** `output_rx_ack` held 0 while sending 0x11 then 0x22 → `output_rx` stays 0x11 and `overrun` pulses once. With `RS232_RX_FIFO_EN`, 5 frames give 0x11..0x44 held and one `overrun`.
- **Reset mid-frame:** assert `rst` = 0 in the middle of data bit 3, release it, then send 0x7E → only 0x7E is delivered.
